// File: rtl/paralelo_serial.sv
// paralelo_serial: byte-to-bit serializer, MSB first, one bit per clk_32f cycle.
// Latency: accept to MSB on data_out is 1..8 cycles depending on byte-slot phase.
// Backpressure: ready = active && !hold_full; one byte of buffering, ready reopens after each drain.
//
// Ports:
//   clk_32f      bit clock, all state changes on its rising edge
//   reset        asynchronous, active-low
//   data_in      parallel byte, sampled only on an accept (valid_in && ready)
//   valid_in     data_in is valid this cycle
//   ready        hold register can take a byte (registers only, never depends on valid_in)
//   data_out     registered serial line
//   active       preamble of MIN_BC commas done, link running
//   sending_data byte currently on data_out is user data rather than a filler comma
module paralelo_serial #(
  parameter logic [7:0] COMMA  = 8'hBC,
  parameter int         MIN_BC = 4      // legal range 1..15
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready,
  output logic       data_out,
  output logic       active,
  output logic       sending_data
);

  localparam logic [3:0] MIN_BC_L = 4'(MIN_BC);

  typedef enum logic {SYNC, RUN} state_t;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [3:0] bc_cnt;
  logic [7:0] shifter;
  logic [7:0] hold;
  logic       hold_full;

  logic       boundary;
  logic       accept;
  logic [7:0] next_byte;

  assign boundary = (bit_cnt == 3'd0);
  assign ready    = active && !hold_full;
  assign accept   = valid_in && ready;

  // Byte chosen for the next slot; only used on a boundary edge.
  always_comb begin
    next_byte = COMMA;
    if (state == RUN && hold_full) begin
      next_byte = hold;
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state        <= SYNC;
      bit_cnt      <= 3'd0;
      bc_cnt       <= 4'd0;
      shifter      <= 8'h00;
      hold         <= 8'h00;
      hold_full    <= 1'b0;
      data_out     <= 1'b0;
      active       <= 1'b0;
      sending_data <= 1'b0;
    end else begin
      if (boundary) begin
        // MSB goes straight to the line; the shifter keeps the remaining 7 bits.
        data_out <= next_byte[7];
        shifter  <= {next_byte[6:0], 1'b0};
        bit_cnt  <= 3'd1;
        case (state)
          SYNC: begin
            sending_data <= 1'b0;
            bc_cnt       <= bc_cnt + 4'd1;
            // The slot that promotes to RUN still carries a comma.
            if (bc_cnt == MIN_BC_L) begin
              state  <= RUN;
              active <= 1'b1;
            end
          end
          RUN: begin
            if (hold_full) begin
              hold_full    <= 1'b0;
              sending_data <= 1'b1;
            end else begin
              sending_data <= 1'b0;
            end
          end
          default: state <= SYNC;
        endcase
      end else begin
        data_out <= shifter[7];
        shifter  <= {shifter[6:0], 1'b0};
        bit_cnt  <= bit_cnt + 3'd1;   // wraps 7 -> 0 onto the next boundary
      end

      // ready is low while hold_full, so this never collides with the drain above.
      // A byte accepted on a boundary edge waits for the following slot.
      if (accept) begin
        hold      <= data_in;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_paralelo_serial.sv
module tb_paralelo_serial;

  localparam logic [7:0] COMMA    = 8'hBC;
  localparam int         MB       = 4;
  localparam int         ACT_EDGE = 1 + 8 * MB;

  logic       clk_32f  = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] data_in  = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready;
  logic       data_out;
  logic       active;
  logic       sending_data;

  int checks = 0;
  int errors = 0;

  // Reference model: slot arithmetic on the edge count since reset, plus a
  // queue of bytes accepted but not yet placed in a slot.
  int         m_n;
  logic [7:0] m_pend[$];
  logic [7:0] m_cur;
  logic       m_dat;

  typedef struct {
    int         n;
    logic       vin;
    logic [7:0] din;
    logic       e_dout;
    logic       e_act;
    logic       e_rdy;
    logic       e_sd;
  } vec_t;

  vec_t tbl[$];

  paralelo_serial #(.COMMA(COMMA), .MIN_BC(MB)) dut (
    .clk_32f      (clk_32f),
    .reset        (reset),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .ready        (ready),
    .data_out     (data_out),
    .active       (active),
    .sending_data (sending_data)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got %b expected %b", name, m_n, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got %h expected %h", name, m_n, act, exp);
    end
  endtask

  function automatic logic m_ready();
    return (m_n >= ACT_EDGE) && (m_pend.size() == 0);
  endfunction

  task automatic m_clear();
    m_n = 0;
    m_pend.delete();
    m_cur = 8'h00;
    m_dat = 1'b0;
  endtask

  // One clock edge: drive inputs, advance the model, compare every output.
  task automatic step(input logic vin, input logic [7:0] din);
    logic rdy_m;
    int   k;
    int   j;
    rdy_m = m_ready();
    chk("ready", ready, rdy_m);
    valid_in = vin;
    data_in  = din;
    @(posedge clk_32f);
    #1;
    m_n++;
    k = (m_n - 1) % 8;
    j = (m_n - 1) / 8;
    if (k == 0) begin
      if (j > MB && m_pend.size() > 0) begin
        m_cur = m_pend.pop_front();
        m_dat = 1'b1;
      end else begin
        m_cur = COMMA;
        m_dat = 1'b0;
      end
    end
    if (vin && rdy_m) m_pend.push_back(din);
    chk("data_out", data_out, m_cur[7-k]);
    chk("active", active, m_n >= ACT_EDGE);
    chk("sending_data", sending_data, m_dat);
    valid_in = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_data_out", data_out, 1'b0);
    chk("rst_active", active, 1'b0);
    chk("rst_sending", sending_data, 1'b0);
    chk("rst_ready", ready, 1'b0);
    repeat (2) @(posedge clk_32f);
    #1;
    reset = 1'b1;
    m_clear();
  endtask

  initial begin
    int         idx;
    int         acc_edge[3];
    logic [7:0] sbytes[3];
    logic [23:0] wire_s;
    logic [31:0] wire_p;
    logic       sd_all;
    logic       sd_any;
    logic       r;
    logic [7:0] b;
    int         i;
    int         w;

    // n, vin, din, exp data_out, exp active, exp ready, exp sending_data
    tbl.push_back('{1,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{2,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{5,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{8,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{10, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{11, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{32, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{33, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{34, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{35, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{40, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{41, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{42, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{43, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{44, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{45, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{46, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{47, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{48, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{49, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{50, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0});

    m_clear();
    #2;
    do_reset();

    // Preamble, SYNC-time valid ignored, single byte A5, valid ignored while held.
    idx = 0;
    for (int n = 1; n <= 52; n++) begin
      if (idx < tbl.size() && tbl[idx].n == n) begin
        step(tbl[idx].vin, tbl[idx].din);
        chk("tbl_data_out", data_out, tbl[idx].e_dout);
        chk("tbl_active", active, tbl[idx].e_act);
        chk("tbl_ready", ready, tbl[idx].e_rdy);
        chk("tbl_sending", sending_data, tbl[idx].e_sd);
        idx++;
      end else begin
        step(1'b0, 8'h00);
      end
    end

    // Streaming with valid held high: back-to-back bytes, no commas between.
    do_reset();
    sbytes[0] = 8'h01;
    sbytes[1] = 8'h02;
    sbytes[2] = 8'h03;
    for (int n = 1; n <= 33; n++) step(1'b0, 8'h00);
    i      = 0;
    wire_s = 24'h0;
    sd_all = 1'b1;
    for (int n = 34; n <= 72; n++) begin
      r = ready;
      step(i < 3, (i < 3) ? sbytes[i] : 8'h00);
      if (r && i < 3) begin
        acc_edge[i] = n;
        i++;
      end
      if (n >= 41 && n <= 64) begin
        wire_s = {wire_s[22:0], data_out};
        sd_all = sd_all & sending_data;
      end
    end
    chkw("stream_acc0", 32'(acc_edge[0]), 32'd34);
    chkw("stream_acc1", 32'(acc_edge[1]), 32'd42);
    chkw("stream_acc2", 32'(acc_edge[2]), 32'd50);
    chkw("stream_wire", 32'(wire_s), 32'h00010203);
    chk("stream_sending", sd_all, 1'b1);

    // Reset mid-byte: byte 5A in flight, 66 held, both must vanish.
    do_reset();
    for (int n = 1; n <= 33; n++) step(1'b0, 8'h00);
    step(1'b1, 8'h5A);
    for (int n = 35; n <= 41; n++) step(1'b0, 8'h00);
    step(1'b1, 8'h66);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    do_reset();
    wire_p = 32'h0;
    sd_any = 1'b0;
    for (int n = 1; n <= 64; n++) begin
      step(1'b0, 8'h00);
      if (n <= 32) wire_p = {wire_p[30:0], data_out};
      if (n == 32) chk("mid_active_pre", active, 1'b0);
      if (n == 33) chk("mid_active_post", active, 1'b1);
      sd_any = sd_any | sending_data;
    end
    chkw("mid_preamble", wire_p, 32'hBCBCBCBC);
    chk("mid_no_stale_data", sd_any, 1'b0);

    // Data byte equal to COMMA goes out as data.
    step(1'b1, 8'hBC);
    w = 0;
    while (!sending_data && w < 16) begin
      step(1'b0, 8'h00);
      w++;
    end
    chk("bc_wait", sending_data, 1'b1);
    b      = {7'b0, data_out};
    sd_all = sending_data;
    repeat (7) begin
      step(1'b0, 8'h00);
      b      = {b[6:0], data_out};
      sd_all = sd_all & sending_data;
    end
    chkw("bc_byte", 32'(b), 32'h000000BC);
    chk("bc_sending", sd_all, 1'b1);

    // Random traffic against the model, with occasional resets.
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      step($urandom_range(0, 3) != 0, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
